// File: rtl/id_pipe.sv
// RV32I decode stage fused with the ID/EX register: forwarding, load-use stall,
// flush, back-pressure and illegal-encoding flagging behind a valid/ready handshake.
module id_pipe #(
    parameter int XLEN       = 32,
    parameter bit ENABLE_FWD = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    output logic            rf_re1,
    output logic            rf_re2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_waddr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            mem_we,
    input  logic [4:0]      mem_waddr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [5:0]      out_opt,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic            out_we,
    output logic [4:0]      out_waddr,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_shamt,
    output logic            out_illegal
);

    localparam logic [6:0] OpcodeNOP = 7'b0000000;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpImm     = 7'b0010011;
    localparam logic [6:0] OpReg     = 7'b0110011;

    localparam logic [5:0] OptNOP   = 6'd0;
    localparam logic [5:0] OptLUI   = 6'd1;
    localparam logic [5:0] OptAUIPC = 6'd2;
    localparam logic [5:0] OptJAL   = 6'd3;
    localparam logic [5:0] OptJALR  = 6'd4;
    localparam logic [5:0] OptBEQ   = 6'd5;
    localparam logic [5:0] OptBNE   = 6'd6;
    localparam logic [5:0] OptBLT   = 6'd7;
    localparam logic [5:0] OptBGE   = 6'd8;
    localparam logic [5:0] OptBLTU  = 6'd9;
    localparam logic [5:0] OptBGEU  = 6'd10;
    localparam logic [5:0] OptLB    = 6'd11;
    localparam logic [5:0] OptLH    = 6'd12;
    localparam logic [5:0] OptLW    = 6'd13;
    localparam logic [5:0] OptLBU   = 6'd14;
    localparam logic [5:0] OptLHU   = 6'd15;
    localparam logic [5:0] OptSB    = 6'd16;
    localparam logic [5:0] OptSH    = 6'd17;
    localparam logic [5:0] OptSW    = 6'd18;
    localparam logic [5:0] OptADDI  = 6'd19;
    localparam logic [5:0] OptSLTI  = 6'd20;
    localparam logic [5:0] OptSLTIU = 6'd21;
    localparam logic [5:0] OptXORI  = 6'd22;
    localparam logic [5:0] OptORI   = 6'd23;
    localparam logic [5:0] OptANDI  = 6'd24;
    localparam logic [5:0] OptSLLI  = 6'd25;
    localparam logic [5:0] OptSRLI  = 6'd26;
    localparam logic [5:0] OptSRAI  = 6'd27;
    localparam logic [5:0] OptADD   = 6'd28;
    localparam logic [5:0] OptSUB   = 6'd29;
    localparam logic [5:0] OptSLL   = 6'd30;
    localparam logic [5:0] OptSLT   = 6'd31;
    localparam logic [5:0] OptSLTU  = 6'd32;
    localparam logic [5:0] OptXOR   = 6'd33;
    localparam logic [5:0] OptSRL   = 6'd34;
    localparam logic [5:0] OptSRA   = 6'd35;
    localparam logic [5:0] OptOR    = 6'd36;
    localparam logic [5:0] OptAND   = 6'd37;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

    logic [5:0]      dec_opt;
    logic [6:0]      dec_opcode;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_shamt;
    logic            dec_we, dec_re1, dec_re2, dec_illegal;

    always_comb begin
        dec_opt     = OptNOP;
        dec_imm     = '0;
        dec_shamt   = '0;
        dec_we      = 1'b0;
        dec_re1     = 1'b0;
        dec_re2     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OpLui:   begin dec_opt = OptLUI;   dec_imm = imm_u; dec_we = 1'b1; end
            OpAuipc: begin dec_opt = OptAUIPC; dec_imm = imm_u; dec_we = 1'b1; end
            OpJal:   begin dec_opt = OptJAL;   dec_imm = imm_j; dec_we = 1'b1; end
            OpJalr: begin
                dec_opt = OptJALR; dec_imm = imm_i; dec_re1 = 1'b1; dec_we = 1'b1;
                dec_illegal = (f3 != 3'd0);
            end
            OpBranch: begin
                dec_imm = imm_b; dec_re1 = 1'b1; dec_re2 = 1'b1;
                case (f3)
                    3'd0:    dec_opt = OptBEQ;
                    3'd1:    dec_opt = OptBNE;
                    3'd4:    dec_opt = OptBLT;
                    3'd5:    dec_opt = OptBGE;
                    3'd6:    dec_opt = OptBLTU;
                    3'd7:    dec_opt = OptBGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpLoad: begin
                dec_imm = imm_i; dec_re1 = 1'b1; dec_we = 1'b1;
                case (f3)
                    3'd0:    dec_opt = OptLB;
                    3'd1:    dec_opt = OptLH;
                    3'd2:    dec_opt = OptLW;
                    3'd4:    dec_opt = OptLBU;
                    3'd5:    dec_opt = OptLHU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpStore: begin
                dec_imm = imm_s; dec_re1 = 1'b1; dec_re2 = 1'b1;
                case (f3)
                    3'd0:    dec_opt = OptSB;
                    3'd1:    dec_opt = OptSH;
                    3'd2:    dec_opt = OptSW;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpImm: begin
                dec_imm = imm_i; dec_re1 = 1'b1; dec_we = 1'b1;
                case (f3)
                    3'd0: dec_opt = OptADDI;
                    3'd2: dec_opt = OptSLTI;
                    3'd3: dec_opt = OptSLTIU;
                    3'd4: dec_opt = OptXORI;
                    3'd6: dec_opt = OptORI;
                    3'd7: dec_opt = OptANDI;
                    3'd1: begin
                        dec_opt = OptSLLI; dec_shamt = in_inst[24:20];
                        dec_illegal = (f7 != 7'h00);
                    end
                    default: begin
                        dec_shamt = in_inst[24:20];
                        if (f7 == 7'h00)      dec_opt = OptSRLI;
                        else if (f7 == 7'h20) dec_opt = OptSRAI;
                        else                  dec_illegal = 1'b1;
                    end
                endcase
            end
            OpReg: begin
                dec_re1 = 1'b1; dec_re2 = 1'b1; dec_we = 1'b1;
                case ({f7, f3})
                    {7'h00, 3'd0}: dec_opt = OptADD;
                    {7'h20, 3'd0}: dec_opt = OptSUB;
                    {7'h00, 3'd1}: dec_opt = OptSLL;
                    {7'h00, 3'd2}: dec_opt = OptSLT;
                    {7'h00, 3'd3}: dec_opt = OptSLTU;
                    {7'h00, 3'd4}: dec_opt = OptXOR;
                    {7'h00, 3'd5}: dec_opt = OptSRL;
                    {7'h20, 3'd5}: dec_opt = OptSRA;
                    {7'h00, 3'd6}: dec_opt = OptOR;
                    {7'h00, 3'd7}: dec_opt = OptAND;
                    default:       dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Undefined encodings travel on as harmless NOPs carrying the illegal flag.
        if (dec_illegal) begin
            dec_opt   = OptNOP;
            dec_imm   = '0;
            dec_shamt = '0;
            dec_we    = 1'b0;
            dec_re1   = 1'b0;
            dec_re2   = 1'b0;
        end
    end

    assign dec_opcode = dec_illegal ? OpcodeNOP : opcode;
    assign rf_raddr1  = in_inst[19:15];
    assign rf_raddr2  = in_inst[24:20];
    assign rf_re1     = dec_re1;
    assign rf_re2     = dec_re2;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, hazard;
    assign ex_hit1  = dec_re1 & (rf_raddr1 != 5'd0) & ex_we  & (ex_waddr  == rf_raddr1);
    assign ex_hit2  = dec_re2 & (rf_raddr2 != 5'd0) & ex_we  & (ex_waddr  == rf_raddr2);
    assign mem_hit1 = dec_re1 & (rf_raddr1 != 5'd0) & mem_we & (mem_waddr == rf_raddr1);
    assign mem_hit2 = dec_re2 & (rf_raddr2 != 5'd0) & mem_we & (mem_waddr == rf_raddr2);

    // Load data is not ready in EX, so an EX load match always stalls.
    assign hazard = ((ex_hit1 | ex_hit2) & ex_is_load)
                  | (!ENABLE_FWD & (ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2));

    logic [XLEN-1:0] opnd1, opnd2;
    always_comb begin
        opnd1 = rf_rdata1;
        if (dec_re1) begin
            if (rf_raddr1 == 5'd0)          opnd1 = '0;
            else if (ex_hit1 & !ex_is_load) opnd1 = ex_wdata;
            else if (mem_hit1)              opnd1 = mem_wdata;
        end
        opnd2 = rf_rdata2;
        if (dec_re2) begin
            if (rf_raddr2 == 5'd0)          opnd2 = '0;
            else if (ex_hit2 & !ex_is_load) opnd2 = ex_wdata;
            else if (mem_hit2)              opnd2 = mem_wdata;
        end
    end

    logic capture;
    assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
    assign capture  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_opcode  <= OpcodeNOP;
            out_opt     <= OptNOP;
            out_rdata1  <= '0;
            out_rdata2  <= '0;
            out_we      <= 1'b0;
            out_waddr   <= '0;
            out_imm     <= '0;
            out_shamt   <= '0;
            out_illegal <= 1'b0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (capture)   out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (capture) begin
                out_pc      <= in_pc;
                out_opcode  <= dec_opcode;
                out_opt     <= dec_opt;
                out_rdata1  <= opnd1;
                out_rdata2  <= opnd2;
                out_we      <= dec_we;
                out_waddr   <= in_inst[11:7];
                out_imm     <= dec_imm;
                out_shamt   <= dec_shamt;
                out_illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: decode, forwarding priority, load-use stall,
// back-pressure, flush, illegal flagging and asynchronous reset.
module tb_id_pipe;

    localparam logic [5:0] OPT_NOP  = 6'd0;
    localparam logic [5:0] OPT_SW   = 6'd18;
    localparam logic [5:0] OPT_ADDI = 6'd19;
    localparam logic [5:0] OPT_SRAI = 6'd27;
    localparam logic [5:0] OPT_ADD  = 6'd28;

    logic        clk, rst, in_valid, flush, out_ready;
    logic [31:0] in_pc, in_inst, rf_rdata1, rf_rdata2, ex_wdata, mem_wdata;
    logic        ex_we, ex_is_load, mem_we;
    logic [4:0]  ex_waddr, mem_waddr;

    logic        in_ready, rf_re1, rf_re2, out_valid, out_we, out_illegal;
    logic [4:0]  rf_raddr1, rf_raddr2, out_waddr, out_shamt;
    logic [31:0] out_pc, out_rdata1, out_rdata2, out_imm;
    logic [6:0]  out_opcode;
    logic [5:0]  out_opt;

    logic        nf_in_ready, nf_re1, nf_re2, nf_valid, nf_we, nf_illegal;
    logic [4:0]  nf_raddr1, nf_raddr2, nf_waddr, nf_shamt;
    logic [31:0] nf_pc, nf_rdata1, nf_rdata2, nf_imm;
    logic [6:0]  nf_opcode;
    logic [5:0]  nf_opt;

    int checks = 0;
    int failures = 0;

    id_pipe #(.XLEN(32), .ENABLE_FWD(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_re1(rf_re1), .rf_re2(rf_re2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_opt(out_opt),
        .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_we(out_we),
        .out_waddr(out_waddr), .out_imm(out_imm), .out_shamt(out_shamt),
        .out_illegal(out_illegal)
    );

    id_pipe #(.XLEN(32), .ENABLE_FWD(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nf_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .rf_raddr1(nf_raddr1), .rf_raddr2(nf_raddr2), .rf_re1(nf_re1), .rf_re2(nf_re2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .out_valid(nf_valid), .out_ready(out_ready), .out_pc(nf_pc),
        .out_opcode(nf_opcode), .out_opt(nf_opt),
        .out_rdata1(nf_rdata1), .out_rdata2(nf_rdata2), .out_we(nf_we),
        .out_waddr(nf_waddr), .out_imm(nf_imm), .out_shamt(nf_shamt),
        .out_illegal(nf_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_inst = 32'h0000_0013;
        rf_rdata1 = 32'hDEAD_0001; rf_rdata2 = 32'hDEAD_0002;
        ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        #1 rst = 1'b0;
        #2;
        chk("rst_valid",   out_valid,   32'd0);
        chk("rst_illegal", out_illegal, 32'd0);
        chk("rst_we",      out_we,      32'd0);
        chk("rst_pc",      out_pc,      32'd0);
        chk("rst_opt",     out_opt,     OPT_NOP);
        chk("rst_opcode",  out_opcode,  32'd0);
        chk("rst_imm",     out_imm,     32'd0);
        @(negedge clk) rst = 1'b1;
        step();

        // addi x1,x0,5
        in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h100;
        #1;
        chk("basic_re1",    rf_re1,    32'd1);
        chk("basic_raddr1", rf_raddr1, 32'd0);
        chk("basic_ready",  in_ready,  32'd1);
        step();
        chk("basic_valid",  out_valid,  32'd1);
        chk("basic_opt",    out_opt,    OPT_ADDI);
        chk("basic_opcode", out_opcode, 32'h13);
        chk("basic_imm",    out_imm,    32'd5);
        chk("basic_waddr",  out_waddr,  32'd1);
        chk("basic_we",     out_we,     32'd1);
        chk("basic_rdata1", out_rdata1, 32'd0);
        chk("basic_pc",     out_pc,     32'h100);

        // add x3,x1,x1 with EX and MEM both matching: EX wins
        in_inst = 32'h0010_81B3; in_pc = 32'h104;
        rf_rdata1 = 32'h99; rf_rdata2 = 32'h99;
        ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h11;
        mem_we = 1'b1; mem_waddr = 5'd1; mem_wdata = 32'h22;
        #1;
        chk("fwd_ex_ready",    in_ready,    32'd1);
        chk("nofwd_ex_ready",  nf_in_ready, 32'd0);
        step();
        chk("fwd_ex_rdata1", out_rdata1, 32'h11);
        chk("fwd_ex_rdata2", out_rdata2, 32'h11);
        chk("fwd_ex_opt",    out_opt,    OPT_ADD);
        chk("fwd_ex_waddr",  out_waddr,  32'd3);

        ex_we = 1'b0; in_pc = 32'h108;
        #1;
        chk("nofwd_mem_ready", nf_in_ready, 32'd0);
        step();
        chk("fwd_mem_rdata1", out_rdata1, 32'h22);
        chk("fwd_mem_rdata2", out_rdata2, 32'h22);
        chk("fwd_mem_pc",     out_pc,     32'h108);

        mem_we = 1'b0; in_pc = 32'h10C;
        #1;
        chk("nofwd_clear_ready", nf_in_ready, 32'd1);
        step();
        chk("rf_rdata1", out_rdata1, 32'h99);

        // srai x4,x1,3
        in_inst = 32'h4030_D213; in_pc = 32'h110;
        step();
        chk("srai_opt",   out_opt,   OPT_SRAI);
        chk("srai_shamt", out_shamt, 32'd3);
        chk("srai_imm",   out_imm,   32'h403);
        chk("srai_waddr", out_waddr, 32'd4);

        // sw x2,-4(x1)
        in_inst = 32'hFE20_AE23; in_pc = 32'h114;
        step();
        chk("sw_opt",    out_opt,    OPT_SW);
        chk("sw_imm",    out_imm,    32'hFFFF_FFFC);
        chk("sw_we",     out_we,     32'd0);
        chk("sw_rdata2", out_rdata2, 32'h99);

        // load-use: add x3,x1,x1 behind a load to x1
        in_inst = 32'h0010_81B3; in_pc = 32'h118;
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'h77;
        #1;
        chk("lu_ready", in_ready, 32'd0);
        step();
        chk("lu_bubble", out_valid, 32'd0);
        ex_we = 1'b0; ex_is_load = 1'b0;
        mem_we = 1'b1; mem_waddr = 5'd1; mem_wdata = 32'h33;
        #1;
        chk("lu_ready2", in_ready, 32'd1);
        step();
        chk("lu_valid",  out_valid,  32'd1);
        chk("lu_rdata1", out_rdata1, 32'h33);
        chk("lu_rdata2", out_rdata2, 32'h33);
        chk("lu_pc",     out_pc,     32'h118);

        // back-pressure, next instruction addi x2,x0,7
        mem_we = 1'b0; out_ready = 1'b0;
        in_inst = 32'h0070_0113; in_pc = 32'h11C;
        #1;
        chk("bp_ready", in_ready, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_valid",  out_valid,  32'd1);
            chk("bp_pc",     out_pc,     32'h118);
            chk("bp_rdata1", out_rdata1, 32'h33);
            chk("bp_opt",    out_opt,    OPT_ADD);
            chk("bp_ready",  in_ready,   32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 32'd1);
        step();
        chk("bp_next_pc",    out_pc,    32'h11C);
        chk("bp_next_imm",   out_imm,   32'd7);
        chk("bp_next_waddr", out_waddr, 32'd2);

        // flush while holding; addi x5,x0,9 must never appear
        flush = 1'b1; in_inst = 32'h0090_0293; in_pc = 32'h120;
        #1;
        chk("flush_ready", in_ready, 32'd0);
        step();
        chk("flush_valid", out_valid, 32'd0);
        chk("flush_pc",    out_pc,    32'h11C);
        flush = 1'b0; in_valid = 1'b0;
        step();
        chk("flush_valid2", out_valid, 32'd0);
        chk("flush_pc2",    out_pc,    32'h11C);

        // illegal encoding
        in_valid = 1'b1; in_inst = 32'hFFFF_FFFF; in_pc = 32'h124;
        #1;
        chk("ill_re1", rf_re1, 32'd0);
        chk("ill_re2", rf_re2, 32'd0);
        step();
        chk("ill_valid",   out_valid,   32'd1);
        chk("ill_illegal", out_illegal, 32'd1);
        chk("ill_we",      out_we,      32'd0);
        chk("ill_opt",     out_opt,     OPT_NOP);
        chk("ill_pc",      out_pc,      32'h124);

        // asynchronous reset between edges
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid",   out_valid,   32'd0);
        chk("arst_illegal", out_illegal, 32'd0);
        chk("arst_pc",      out_pc,      32'd0);
        @(negedge clk) rst = 1'b1;
        step();
        chk("arst_no_capture", out_valid, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
